// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller and its ALU function decoder.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_RTEXE   = 4'd2,
    ST_IMMEXE  = 4'd3,
    ST_ALUWB   = 4'd4,
    ST_MEMADR  = 4'd5,
    ST_MEMRD   = 4'd6,
    ST_MEMWB   = 4'd7,
    ST_MEMWR   = 4'd8,
    ST_BRANCH  = 4'd9,
    ST_JUMP    = 4'd10,
    ST_ILLEGAL = 4'd11
  } state_e;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;  // bltz
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLTU = 6'b101011;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b111;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_SLTU = 3'b000;
  localparam logic [2:0] ALU_LUI  = 3'b011;
  localparam logic [2:0] ALU_PASS = 3'b010;

  // ALU operand B select
  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source select
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_func_decode.sv
// Combinational {op, funct} -> ALU control decode, shared with the single-cycle build.
module alu_func_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o
);

  // Map opcode (and funct for R-type) onto the ALU operation
  always_comb begin
    alucontrol_o = ALU_PASS;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          F_ADDU:  alucontrol_o = ALU_ADD;
          F_SUBU:  alucontrol_o = ALU_SUB;
          F_AND:   alucontrol_o = ALU_AND;
          F_OR:    alucontrol_o = ALU_OR;
          F_SLTU:  alucontrol_o = ALU_SLTU;
          default: alucontrol_o = ALU_PASS;
        endcase
      end
      OP_ADDIU, OP_LW, OP_SW: alucontrol_o = ALU_ADD;
      OP_ORI:                 alucontrol_o = ALU_OR;
      OP_LUI:                 alucontrol_o = ALU_LUI;
      OP_BEQ:                 alucontrol_o = ALU_SUB;
      default:                alucontrol_o = ALU_PASS;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencer: state register, memory wait counter and datapath control decode.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 4
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pcwrite,
  output logic        irwrite,
  output logic        iord,
  output logic        memread,
  output logic        memwrite,
  output logic        memtoreg,
  output logic        regwrite,
  output logic [4:0]  destreg,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic [2:0]  alucontrol,
  output logic [1:0]  pcsrc,
  output logic        illegal,
  output logic        memerr,
  output logic [3:0]  state
);

  // The counter reaches all-ones on the stalled cycle where it holds all-ones minus one,
  // so the timeout fires on the (2**TIMEOUT_W-1)th consecutive stalled cycle.
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = {TIMEOUT_W{1'b1}} - 1'b1;

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_q, wait_d;

  logic [5:0] op, funct;
  logic [2:0] alu_dec;
  logic       stall, timeout;
  logic       unused_instr;

  assign op           = instr[31:26];
  assign funct        = instr[5:0];
  assign unused_instr = ^{instr[25:21], instr[10:6]};

  alu_func_decode u_alu_dec (
    .op_i         (op),
    .funct_i      (funct),
    .alucontrol_o (alu_dec)
  );

  assign stall   = ((state_q == ST_FETCH) || (state_q == ST_MEMRD) || (state_q == ST_MEMWR))
                   && !mem_ready;
  assign timeout = stall && (wait_q == WAIT_LAST);

  // Next-state selection and wait counter update
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (op)
          OP_RTYPE:                 state_d = ST_RTEXE;
          OP_LW, OP_SW:             state_d = ST_MEMADR;
          OP_BEQ, OP_REGIMM:        state_d = ST_BRANCH;
          OP_ADDIU, OP_ORI, OP_LUI: state_d = ST_IMMEXE;
          OP_J:                     state_d = ST_JUMP;
          default:                  state_d = ST_ILLEGAL;
        endcase
      end
      ST_RTEXE, ST_IMMEXE: state_d = ST_ALUWB;
      ST_MEMADR: begin
        if (op == OP_LW)      state_d = ST_MEMRD;
        else if (op == OP_SW) state_d = ST_MEMWR;
        else                  state_d = ST_FETCH;
      end
      ST_MEMRD:  if (mem_ready) state_d = ST_MEMWB;
      ST_MEMWR:  if (mem_ready) state_d = ST_FETCH;
      ST_ALUWB, ST_MEMWB, ST_BRANCH, ST_JUMP, ST_ILLEGAL: state_d = ST_FETCH;
      default:   state_d = ST_FETCH;
    endcase
    if (timeout) state_d = ST_FETCH;

    // A FETCH timeout keeps the state unchanged, hence the explicit clear on timeout.
    if (timeout || (state_d != state_q)) wait_d = '0;
    else if (stall)                      wait_d = wait_q + 1'b1;
    else                                 wait_d = wait_q;
  end

  // State and wait counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Datapath control decode from the current state and IR contents
  always_comb begin
    pcwrite    = 1'b0;
    irwrite    = 1'b0;
    iord       = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    destreg    = '0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_RT;
    alucontrol = ALU_PASS;
    pcsrc      = PC_ALU;
    illegal    = 1'b0;
    memerr     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        memread    = 1'b1;
        alusrcb    = SRCB_FOUR;
        alucontrol = ALU_ADD;
        pcwrite    = mem_ready;
        irwrite    = mem_ready;
      end
      ST_DECODE: begin
        alusrcb    = SRCB_IMMSH;
        alucontrol = ALU_ADD;
      end
      ST_RTEXE: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_RT;
        alucontrol = alu_dec;
      end
      ST_IMMEXE: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        alucontrol = alu_dec;
      end
      ST_ALUWB: begin
        regwrite = 1'b1;
        destreg  = (op == OP_RTYPE) ? instr[15:11] : instr[20:16];
      end
      ST_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        alucontrol = ALU_ADD;
      end
      ST_MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
      end
      ST_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        destreg  = instr[20:16];
      end
      ST_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      ST_BRANCH: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_RT;
        alucontrol = alu_dec;
        pcsrc      = PC_ALUOUT;
        pcwrite    = zero;
      end
      ST_JUMP: begin
        pcsrc   = PC_JUMP;
        pcwrite = 1'b1;
      end
      ST_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase

    if (timeout) begin
      pcwrite  = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      memerr   = 1'b1;
    end

    if (!reset) begin
      pcwrite  = 1'b0;
      irwrite  = 1'b0;
      memread  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
      memerr   = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: cycle vector table plus timeout/reset sequences.
module tb_multicycle_controller;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_RTEXE = 4'd2, S_IMMEXE = 4'd3,
                         S_ALUWB = 4'd4, S_MEMADR = 4'd5, S_MEMRD = 4'd6, S_MEMWB = 4'd7,
                         S_MEMWR = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_ILLEGAL = 4'd11;

  localparam logic [31:0] I_ADDU = 32'h0085_1821;  // rd=3
  localparam logic [31:0] I_LW   = 32'h8C43_0004;  // rt=3
  localparam logic [31:0] I_BEQ  = 32'h10A6_FFFE;
  localparam logic [31:0] I_ILL  = 32'hFC00_0000;  // op 0x3F
  localparam logic [31:0] I_J    = 32'h0800_0010;
  localparam logic [31:0] I_ORI  = 32'h34A7_00FF;  // rt=7
  localparam logic [31:0] I_LUI  = 32'h3C0A_1234;  // rt=10
  localparam logic [31:0] I_SUBU = 32'h00A6_0023;  // rd=0
  localparam logic [31:0] I_SYSC = 32'h00A6_180C;  // funct 001100, rd=3
  localparam logic [31:0] I_BLTZ = 32'h04A0_FFFF;
  localparam logic [31:0] I_SW   = 32'hACA7_0008;

  typedef struct packed {
    logic       pcwrite, irwrite, iord, memread, memwrite, memtoreg, regwrite;
    logic [4:0] destreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic [1:0] pcsrc;
    logic       illegal, memerr;
  } outs_t;

  typedef struct packed {
    outs_t exp;
    outs_t care;
  } chk_t;

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] ins;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    chk_t        c;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        pcwrite, irwrite, iord, memread, memwrite, memtoreg, regwrite;
  logic [4:0]  destreg;
  logic        alusrca;
  logic [1:0]  alusrcb;
  logic [2:0]  alucontrol;
  logic [1:0]  pcsrc;
  logic        illegal, memerr;
  logic [3:0]  state;
  outs_t       act;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vt[$];

  multicycle_controller #(.TIMEOUT_W(4)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .irwrite(irwrite), .iord(iord), .memread(memread),
    .memwrite(memwrite), .memtoreg(memtoreg), .regwrite(regwrite), .destreg(destreg),
    .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol), .pcsrc(pcsrc),
    .illegal(illegal), .memerr(memerr), .state(state)
  );

  assign act = {pcwrite, irwrite, iord, memread, memwrite, memtoreg, regwrite, destreg,
                alusrca, alusrcb, alucontrol, pcsrc, illegal, memerr};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, a, e);
    end
  endtask

  // Expected-output builders: enables, destreg and pulses are always checked.
  function automatic chk_t base();
    chk_t c;
    c.exp = '0; c.care = '0;
    c.care.pcwrite = 1'b1; c.care.irwrite = 1'b1; c.care.memread = 1'b1;
    c.care.memwrite = 1'b1; c.care.regwrite = 1'b1; c.care.destreg = '1;
    c.care.illegal = 1'b1; c.care.memerr = 1'b1;
    return c;
  endfunction

  function automatic chk_t e_fetch(input logic rdy);
    chk_t c = base();
    c.exp.memread = 1'b1; c.exp.pcwrite = rdy; c.exp.irwrite = rdy;
    c.exp.alusrcb = 2'b01; c.exp.alucontrol = 3'b101;
    c.care.iord = 1'b1; c.care.alusrca = 1'b1; c.care.alusrcb = '1;
    c.care.alucontrol = '1; c.care.pcsrc = '1;
    return c;
  endfunction

  function automatic chk_t e_decode();
    chk_t c = base();
    c.exp.alusrcb = 2'b11; c.exp.alucontrol = 3'b101;
    c.care.alusrca = 1'b1; c.care.alusrcb = '1; c.care.alucontrol = '1;
    return c;
  endfunction

  function automatic chk_t e_exe(input logic [1:0] srcb, input logic [2:0] aluc);
    chk_t c = base();
    c.exp.alusrca = 1'b1; c.exp.alusrcb = srcb; c.exp.alucontrol = aluc;
    c.care.alusrca = 1'b1; c.care.alusrcb = '1; c.care.alucontrol = '1;
    return c;
  endfunction

  function automatic chk_t e_wb(input logic mtr, input logic [4:0] dest);
    chk_t c = base();
    c.exp.regwrite = 1'b1; c.exp.memtoreg = mtr; c.exp.destreg = dest;
    c.care.memtoreg = 1'b1;
    return c;
  endfunction

  function automatic chk_t e_mem(input logic wr);
    chk_t c = base();
    c.exp.iord = 1'b1; c.exp.memread = !wr; c.exp.memwrite = wr;
    c.care.iord = 1'b1;
    return c;
  endfunction

  function automatic chk_t e_branch(input logic [2:0] aluc, input logic z);
    chk_t c = e_exe(2'b00, aluc);
    c.exp.pcsrc = 2'b01; c.exp.pcwrite = z; c.care.pcsrc = '1;
    return c;
  endfunction

  function automatic chk_t e_jump();
    chk_t c = base();
    c.exp.pcsrc = 2'b10; c.exp.pcwrite = 1'b1; c.care.pcsrc = '1;
    return c;
  endfunction

  function automatic chk_t e_illegal();
    chk_t c = base();
    c.exp.illegal = 1'b1;
    return c;
  endfunction

  task automatic add(input string nm, input logic rst, input logic [31:0] ins, input logic z,
                     input logic rdy, input logic [3:0] st, input chk_t c);
    vec_t v;
    v.name = nm; v.rst = rst; v.ins = ins; v.z = z; v.rdy = rdy; v.st = st; v.c = c;
    vt.push_back(v);
  endtask

  // Drive one cycle's inputs on the falling edge and let them settle.
  task automatic step(input logic rst, input logic [31:0] ins, input logic z, input logic rdy);
    @(negedge clk);
    reset = rst; instr = ins; zero = z; mem_ready = rdy;
    #1;
  endtask

  initial begin
    // Cycle-by-cycle table: inputs for the cycle and the outputs expected during it.
    for (int i = 0; i < 3; i++) add("reset", 0, I_ADDU, 0, 1, S_FETCH, base());
    add("addu_fetch",   1, I_ADDU, 0, 1, S_FETCH,  e_fetch(1));
    add("addu_decode",  1, I_ADDU, 0, 1, S_DECODE, e_decode());
    add("addu_rtexe",   1, I_ADDU, 0, 1, S_RTEXE,  e_exe(2'b00, 3'b101));
    add("addu_aluwb",   1, I_ADDU, 0, 1, S_ALUWB,  e_wb(0, 5'd3));
    add("fetch_stall",  1, I_LW,   0, 0, S_FETCH,  e_fetch(0));
    add("lw_fetch",     1, I_LW,   0, 1, S_FETCH,  e_fetch(1));
    add("lw_decode",    1, I_LW,   0, 1, S_DECODE, e_decode());
    add("lw_memadr",    1, I_LW,   0, 1, S_MEMADR, e_exe(2'b10, 3'b101));
    add("lw_memrd1",    1, I_LW,   0, 0, S_MEMRD,  e_mem(0));
    add("lw_memrd2",    1, I_LW,   0, 0, S_MEMRD,  e_mem(0));
    add("lw_memrd3",    1, I_LW,   0, 1, S_MEMRD,  e_mem(0));
    add("lw_memwb",     1, I_LW,   0, 1, S_MEMWB,  e_wb(1, 5'd3));
    add("beq1_fetch",   1, I_BEQ,  1, 1, S_FETCH,  e_fetch(1));
    add("beq1_decode",  1, I_BEQ,  1, 1, S_DECODE, e_decode());
    add("beq1_taken",   1, I_BEQ,  1, 1, S_BRANCH, e_branch(3'b001, 1));
    add("beq0_fetch",   1, I_BEQ,  0, 1, S_FETCH,  e_fetch(1));
    add("beq0_decode",  1, I_BEQ,  0, 1, S_DECODE, e_decode());
    add("beq0_nottkn",  1, I_BEQ,  0, 1, S_BRANCH, e_branch(3'b001, 0));
    add("ill_fetch",    1, I_ILL,  0, 1, S_FETCH,  e_fetch(1));
    add("ill_decode",   1, I_ILL,  0, 1, S_DECODE, e_decode());
    add("ill_pulse",    1, I_ILL,  0, 1, S_ILLEGAL, e_illegal());
    add("j_fetch",      1, I_J,    0, 1, S_FETCH,  e_fetch(1));
    add("j_decode",     1, I_J,    0, 1, S_DECODE, e_decode());
    add("j_jump",       1, I_J,    0, 1, S_JUMP,   e_jump());
    add("ori_fetch",    1, I_ORI,  0, 1, S_FETCH,  e_fetch(1));
    add("ori_decode",   1, I_ORI,  0, 1, S_DECODE, e_decode());
    add("ori_immexe",   1, I_ORI,  0, 1, S_IMMEXE, e_exe(2'b10, 3'b110));
    add("ori_aluwb",    1, I_ORI,  0, 1, S_ALUWB,  e_wb(0, 5'd7));
    add("lui_fetch",    1, I_LUI,  0, 1, S_FETCH,  e_fetch(1));
    add("lui_decode",   1, I_LUI,  0, 1, S_DECODE, e_decode());
    add("lui_immexe",   1, I_LUI,  0, 1, S_IMMEXE, e_exe(2'b10, 3'b011));
    add("lui_aluwb",    1, I_LUI,  0, 1, S_ALUWB,  e_wb(0, 5'd10));
    add("subu_fetch",   1, I_SUBU, 0, 1, S_FETCH,  e_fetch(1));
    add("subu_decode",  1, I_SUBU, 0, 1, S_DECODE, e_decode());
    add("subu_rtexe",   1, I_SUBU, 0, 1, S_RTEXE,  e_exe(2'b00, 3'b001));
    add("subu_rd0_wb",  1, I_SUBU, 0, 1, S_ALUWB,  e_wb(0, 5'd0));
    add("sysc_fetch",   1, I_SYSC, 0, 1, S_FETCH,  e_fetch(1));
    add("sysc_decode",  1, I_SYSC, 0, 1, S_DECODE, e_decode());
    add("sysc_rtexe",   1, I_SYSC, 0, 1, S_RTEXE,  e_exe(2'b00, 3'b010));
    add("sysc_aluwb",   1, I_SYSC, 0, 1, S_ALUWB,  e_wb(0, 5'd3));
    add("bltz_fetch",   1, I_BLTZ, 1, 1, S_FETCH,  e_fetch(1));
    add("bltz_decode",  1, I_BLTZ, 1, 1, S_DECODE, e_decode());
    add("bltz_branch",  1, I_BLTZ, 1, 1, S_BRANCH, e_branch(3'b010, 1));
    add("sw_fetch",     1, I_SW,   0, 1, S_FETCH,  e_fetch(1));
    add("sw_decode",    1, I_SW,   0, 1, S_DECODE, e_decode());
    add("sw_memadr",    1, I_SW,   0, 1, S_MEMADR, e_exe(2'b10, 3'b101));
    add("sw_memwr1",    1, I_SW,   0, 0, S_MEMWR,  e_mem(1));
    add("sw_memwr2",    1, I_SW,   0, 1, S_MEMWR,  e_mem(1));
    add("sw_done",      1, I_SW,   0, 0, S_FETCH,  e_fetch(0));

    foreach (vt[i]) begin
      step(vt[i].rst, vt[i].ins, vt[i].z, vt[i].rdy);
      chk({vt[i].name, " state"}, 32'(state), 32'(vt[i].st));
      chk({vt[i].name, " outs"}, 32'(act & vt[i].c.care), 32'(vt[i].c.exp & vt[i].c.care));
    end

    // sw that never completes: memwrite held for 14 cycles, memerr on the 15th.
    step(1, I_SW, 0, 1);
    step(1, I_SW, 0, 1);
    step(1, I_SW, 0, 1);
    chk("to_memadr state", 32'(state), 32'(S_MEMADR));
    for (int k = 1; k <= 14; k++) begin
      step(1, I_SW, 0, 0);
      chk($sformatf("to_hold%0d state", k), 32'(state), 32'(S_MEMWR));
      chk($sformatf("to_hold%0d wr/err", k), {30'd0, memwrite, memerr}, 32'b10);
    end
    step(1, I_SW, 0, 0);
    chk("to_fire state", 32'(state), 32'(S_MEMWR));
    chk("to_fire wr/err", {30'd0, memwrite, memerr}, 32'b01);
    // Counter restarts in FETCH: 14 quiet stalls, then a FETCH timeout.
    for (int k = 1; k <= 14; k++) begin
      step(1, I_SW, 0, 0);
      chk($sformatf("fto_hold%0d st/err", k), {27'd0, state, memerr}, {27'd0, S_FETCH, 1'b0});
    end
    step(1, I_SW, 0, 0);
    chk("fto_fire err/irw", {30'd0, memerr, irwrite}, 32'b10);
    step(1, I_SW, 0, 0);
    chk("fto_after st/err", {27'd0, state, memerr}, {27'd0, S_FETCH, 1'b0});

    // mem_ready on the would-be timeout cycle wins.
    step(1, I_SW, 0, 1);
    step(1, I_SW, 0, 1);
    step(1, I_SW, 0, 1);
    for (int k = 1; k <= 14; k++) step(1, I_SW, 0, 0);
    chk("win_pre state", 32'(state), 32'(S_MEMWR));
    step(1, I_SW, 0, 1);
    chk("win_edge wr/err", {30'd0, memwrite, memerr}, 32'b10);
    step(1, I_SW, 0, 0);
    chk("win_after state", 32'(state), 32'(S_FETCH));

    // Reset asserted in the middle of a MEMWR hold.
    step(1, I_SW, 0, 1);
    step(1, I_SW, 0, 1);
    step(1, I_SW, 0, 1);
    step(1, I_SW, 0, 0);
    step(1, I_SW, 0, 0);
    chk("rstmid_pre wr", 32'(memwrite), 32'd1);
    #1;
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("rstmid state", 32'(state), 32'(S_FETCH));
    chk("rstmid enables", {27'd0, pcwrite, irwrite, memread, memwrite, regwrite}, 32'd0);
    step(0, I_SW, 0, 1);
    chk("rstmid_hold state", 32'(state), 32'(S_FETCH));
    step(1, I_SW, 0, 1);
    chk("rstmid_rel st/irw", {27'd0, state, irwrite}, {27'd0, S_FETCH, 1'b1});
    step(1, I_SW, 0, 1);
    chk("rstmid_rel decode", 32'(state), 32'(S_DECODE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
